// File: rtl/mem_readback.sv
// Streams an inclusive, wrapping address range from a sync-read memory over a valid/ready port.
// Optional MEM_READBACK_CHECKSUM_EN appends a modular-sum beat after the last data word.
module mem_readback #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_SEND  = 3'd3,
`ifdef MEM_READBACK_CHECKSUM_EN
    S_CKSUM = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
`ifdef MEM_READBACK_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
`endif

  logic hs_c;
  logic at_end_c;

  assign hs_c     = out_valid_q & out_ready;
  assign at_end_c = (cur_addr_q == end_q);

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    end_d       = end_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef MEM_READBACK_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d = start_addr;
          end_d      = end_addr;
`ifdef MEM_READBACK_CHECKSUM_EN
          sum_d      = '0;
`endif
          state_d    = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        out_data_d  = mem_rdata;
        out_valid_d = 1'b1;
`ifndef MEM_READBACK_CHECKSUM_EN
        out_last_d  = at_end_c;
`endif
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (hs_c) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
`ifdef MEM_READBACK_CHECKSUM_EN
          sum_d       = sum_q + out_data_q;
`endif
          if (at_end_c) begin
`ifdef MEM_READBACK_CHECKSUM_EN
            // The sum beat goes out immediately after the last data beat
            out_data_d  = sum_q + out_data_q;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            state_d     = S_CKSUM;
`else
            state_d     = S_DONE;
`endif
          end else begin
            cur_addr_d = cur_addr_q + ADDR_W'(1);
            state_d    = S_FETCH;
          end
        end
      end
`ifdef MEM_READBACK_CHECKSUM_EN
      S_CKSUM: begin
        if (hs_c) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      end_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef MEM_READBACK_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      end_q       <= end_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef MEM_READBACK_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // Memory strobe decodes straight from the state register
  assign mem_re    = (state_q == S_FETCH);
  assign mem_addr  = (state_q == S_FETCH) ? cur_addr_q : '0;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule
